// File: rtl/pifo_gpfc_pkg.sv
// pifo_gpfc_pkg: shared widths, element layout, pack/unpack helpers and FSM states for the gpfc PIFO
package pifo_gpfc_pkg;
  localparam int PIFO_DEPTH         = 16;
  localparam int ELEMENT_COS_WIDTH  = 3;
  localparam int ELEMENT_RANK_WIDTH = 6;
  localparam int PKT_ADDRESS_WIDTH  = 12;
  localparam int ELEMENT_WIDTH      = 1 + ELEMENT_COS_WIDTH + ELEMENT_RANK_WIDTH + PKT_ADDRESS_WIDTH;
  localparam int ADDR_LSB           = 0;
  localparam int RANK_LSB           = ADDR_LSB + PKT_ADDRESS_WIDTH;
  localparam int COS_LSB            = RANK_LSB + ELEMENT_RANK_WIDTH;
  localparam int VALID_BIT          = COS_LSB + ELEMENT_COS_WIDTH;
  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DONE} state_t;
  function automatic logic [ELEMENT_WIDTH-1:0] pack_element(
    input logic valid,
    input logic [ELEMENT_COS_WIDTH-1:0] cos,
    input logic [ELEMENT_RANK_WIDTH-1:0] rank,
    input logic [PKT_ADDRESS_WIDTH-1:0] addr
  );
    return {valid, cos, rank, addr};
  endfunction
  function automatic logic element_valid(input logic [ELEMENT_WIDTH-1:0] e);
    return e[VALID_BIT];
  endfunction
  function automatic logic [ELEMENT_RANK_WIDTH-1:0] element_rank(input logic [ELEMENT_WIDTH-1:0] e);
    return e[RANK_LSB +: ELEMENT_RANK_WIDTH];
  endfunction
  function automatic logic [PKT_ADDRESS_WIDTH-1:0] element_addr(input logic [ELEMENT_WIDTH-1:0] e);
    return e[ADDR_LSB +: PKT_ADDRESS_WIDTH];
  endfunction
endpackage

// File: rtl/pifo_gpfc_rank_cmp.sv
// pifo_gpfc_rank_cmp: decides whether a new element outranks the head atom (invalid head always loses)
//   new_rank_i   new element rank
//   head_valid_i head atom valid bit
//   head_rank_i  head atom rank
//   new_wins_o   new element strictly more significant than head
module pifo_gpfc_rank_cmp #(
  parameter int RANK_WIDTH = 6
) (
  input  logic [RANK_WIDTH-1:0] new_rank_i,
  input  logic                  head_valid_i,
  input  logic [RANK_WIDTH-1:0] head_rank_i,
  output logic                  new_wins_o
);
  // strict less-than: ties stay in the array so equal ranks leave in FIFO order
  assign new_wins_o = ~head_valid_i | (new_rank_i < head_rank_i);
endmodule

// File: rtl/pifo_gpfc_enq_deq_ctrl.sv
// pifo_gpfc_enq_deq_ctrl: enqueue/dequeue/flush control in front of the gpfc PIFO atom array
//   clk, rstn (sync, active-low)
//   s_enq_*        enqueue channel (valid/ready, cos, rank, addr)
//   s_deq_*        dequeue request channel (valid/ready)
//   in_pifo_head   head atom element; out_pifo_input/out_ctl_insert/out_ctl_pop drive the array
//   m_deq_*        registered dequeue result pulse
//   in_flush       flush request; out_count/full/empty/busy status
module pifo_gpfc_enq_deq_ctrl
  import pifo_gpfc_pkg::*;
#(
  parameter int DEPTH              = PIFO_DEPTH,
  parameter int ELEMENT_COS_WIDTH  = pifo_gpfc_pkg::ELEMENT_COS_WIDTH,
  parameter int ELEMENT_RANK_WIDTH = pifo_gpfc_pkg::ELEMENT_RANK_WIDTH,
  parameter int PKT_ADDRESS_WIDTH  = pifo_gpfc_pkg::PKT_ADDRESS_WIDTH,
  parameter int ELEMENT_WIDTH      = 1 + ELEMENT_COS_WIDTH + ELEMENT_RANK_WIDTH + PKT_ADDRESS_WIDTH,
  parameter int CW                 = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          s_enq_valid,
  output logic                          s_enq_ready,
  input  logic [ELEMENT_COS_WIDTH-1:0]  s_enq_cos,
  input  logic [ELEMENT_RANK_WIDTH-1:0] s_enq_rank,
  input  logic [PKT_ADDRESS_WIDTH-1:0]  s_enq_addr,
  input  logic                          s_deq_valid,
  output logic                          s_deq_ready,
  input  logic [ELEMENT_WIDTH-1:0]      in_pifo_head,
  output logic [ELEMENT_WIDTH-1:0]      out_pifo_input,
  output logic                          out_ctl_insert,
  output logic                          out_ctl_pop,
  output logic                          m_deq_valid,
  output logic [ELEMENT_WIDTH-1:0]      m_deq_element,
  input  logic                          in_flush,
  output logic [CW-1:0]                 out_count,
  output logic                          out_full,
  output logic                          out_empty,
  output logic                          out_busy
);
  state_t                   state_q, state_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     deq_valid_q;
  logic [ELEMENT_WIDTH-1:0] deq_element_q, deq_element_d;
  logic                     run, enq_fire, deq_fire, new_wins, bypass;
  // ready drops in the very cycle a flush is requested so nothing races the drain
  assign run         = rstn & (state_q == ST_RUN) & ~in_flush;
  assign out_full    = count_q == CW'(DEPTH);
  assign out_empty   = count_q == '0;
  assign out_count   = count_q;
  assign out_busy    = state_q != ST_RUN;
  assign s_deq_ready = run & ~out_empty;
  assign deq_fire    = s_deq_valid & s_deq_ready;
  // a simultaneous dequeue frees a slot, so a full array can still accept
  assign s_enq_ready = run & (~out_full | deq_fire);
  assign enq_fire    = s_enq_valid & s_enq_ready;
  pifo_gpfc_rank_cmp #(.RANK_WIDTH(ELEMENT_RANK_WIDTH)) u_rank_cmp (
    .new_rank_i   (s_enq_rank),
    .head_valid_i (in_pifo_head[ELEMENT_WIDTH-1]),
    .head_rank_i  (in_pifo_head[PKT_ADDRESS_WIDTH +: ELEMENT_RANK_WIDTH]),
    .new_wins_o   (new_wins)
  );
  // the atoms cannot pop the head and insert a better one at once; hand the new element straight out
  assign bypass         = enq_fire & deq_fire & new_wins;
  assign out_ctl_insert = enq_fire & ~bypass;
  assign out_ctl_pop    = (deq_fire & ~bypass) | (rstn & (state_q == ST_FLUSH));
  // valid bit follows insert so the atoms never latch an element they were not told to take
  assign out_pifo_input = rstn ? {out_ctl_insert, s_enq_cos, s_enq_rank, s_enq_addr} : '0;
  assign m_deq_valid    = deq_valid_q;
  assign m_deq_element  = deq_element_q;
  always_comb begin
    state_d       = state_q == ST_RUN   ? (in_flush ? (out_empty ? ST_DONE : ST_FLUSH) : ST_RUN) :
                    state_q == ST_FLUSH ? (count_q <= CW'(1) ? ST_DONE : ST_FLUSH) : ST_RUN;
    count_d       = state_q == ST_FLUSH ? count_q - CW'(!out_empty) :
                    count_q + CW'(enq_fire) - CW'(deq_fire);
    deq_element_d = bypass ? {1'b1, s_enq_cos, s_enq_rank, s_enq_addr} : in_pifo_head;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_RUN;
      count_q       <= '0;
      deq_valid_q   <= 1'b0;
      deq_element_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      deq_valid_q <= deq_fire;
      if (deq_fire) deq_element_q <= deq_element_d;
    end
  end
  assert property (@(posedge clk) disable iff (!rstn) !(deq_fire && out_empty));
  assert property (@(posedge clk) disable iff (!rstn) !(out_ctl_insert && out_full && !out_ctl_pop));
endmodule

// File: tb/tb_pifo_gpfc_enq_deq_ctrl.sv
// tb_pifo_gpfc_enq_deq_ctrl: directed scoreboard bench with a behavioural atom-array model
module tb_pifo_gpfc_enq_deq_ctrl;
  import pifo_gpfc_pkg::*;
  localparam int EW = ELEMENT_WIDTH;
  localparam int CW = $clog2(PIFO_DEPTH + 1);
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_enq_valid = 1'b0, s_enq_ready;
  logic [2:0]    s_enq_cos = '0;
  logic [5:0]    s_enq_rank = '0;
  logic [11:0]   s_enq_addr = '0;
  logic          s_deq_valid = 1'b0, s_deq_ready;
  logic [EW-1:0] in_pifo_head = '0, out_pifo_input, m_deq_element;
  logic          out_ctl_insert, out_ctl_pop, m_deq_valid;
  logic          in_flush = 1'b0;
  logic [CW-1:0] out_count;
  logic          out_full, out_empty, out_busy;
  int            tests = 0, fails = 0, cyc = 0;
  logic [EW-1:0] arr[$];
  logic [EW-1:0] exp_q[$];
  int            due_q[$];
  pifo_gpfc_enq_deq_ctrl dut (
    .clk(clk), .rstn(rstn),
    .s_enq_valid(s_enq_valid), .s_enq_ready(s_enq_ready),
    .s_enq_cos(s_enq_cos), .s_enq_rank(s_enq_rank), .s_enq_addr(s_enq_addr),
    .s_deq_valid(s_deq_valid), .s_deq_ready(s_deq_ready),
    .in_pifo_head(in_pifo_head), .out_pifo_input(out_pifo_input),
    .out_ctl_insert(out_ctl_insert), .out_ctl_pop(out_ctl_pop),
    .m_deq_valid(m_deq_valid), .m_deq_element(m_deq_element),
    .in_flush(in_flush), .out_count(out_count),
    .out_full(out_full), .out_empty(out_empty), .out_busy(out_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    int  p;
    bit  found;
    if (!rstn) arr.delete();
    else begin
      if (out_ctl_pop && arr.size() > 0) void'(arr.pop_front());
      if (out_ctl_insert) begin
        p = arr.size();
        found = 1'b0;
        for (int i = 0; i < arr.size(); i++)
          if (!found && element_rank(arr[i]) > element_rank(out_pifo_input)) begin
            p = i;
            found = 1'b1;
          end
        arr.insert(p, out_pifo_input);
      end
    end
    in_pifo_head <= arr.size() > 0 ? arr[0] : '0;
  end
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int d;
    if (rstn && m_deq_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL deq_unexpected actual=%h required=no_pulse", m_deq_element);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        if (m_deq_element !== e || cyc != d) begin
          fails++;
          $display("FAIL deq_element actual=%h@%0d required=%h@%0d", m_deq_element, cyc, e, d);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  function automatic logic [EW-1:0] el(input logic [2:0] c, input logic [5:0] r, input logic [11:0] a);
    return pack_element(1'b1, c, r, a);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic expect_deq(input logic [EW-1:0] e);
    exp_q.push_back(e);
    due_q.push_back(cyc + 1);
  endtask
  task automatic set_enq(input logic v, input logic [2:0] c, input logic [5:0] r, input logic [11:0] a);
    s_enq_valid = v;
    s_enq_cos   = c;
    s_enq_rank  = r;
    s_enq_addr  = a;
  endtask
  task automatic enq(input logic [2:0] c, input logic [5:0] r, input logic [11:0] a);
    set_enq(1'b1, c, r, a);
    step();
    s_enq_valid = 1'b0;
  endtask
  task automatic deq(input logic [EW-1:0] e);
    s_deq_valid = 1'b1;
    expect_deq(e);
    step();
    s_deq_valid = 1'b0;
  endtask
  task automatic do_reset();
    s_enq_valid = 1'b0;
    s_deq_valid = 1'b0;
    in_flush    = 1'b0;
    step();
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask
  initial begin
    int busy_n, pop_n;
    step();
    set_enq(1'b1, 3'd1, 6'd1, 12'h1);
    step();
    #1;
    chk("rst_count", 32'(out_count), 0);
    chk("rst_empty", 32'(out_empty), 1);
    chk("rst_busy", 32'(out_busy), 0);
    chk("rst_m_valid", 32'(m_deq_valid), 0);
    chk("rst_m_elem", 32'(m_deq_element), 0);
    chk("rst_strobes", {30'd0, out_ctl_insert, out_ctl_pop}, 0);
    chk("rst_pifo_input", 32'(out_pifo_input), 0);
    s_enq_valid = 1'b0;
    rstn = 1'b1;
    step();
    // 1: rank order 2,5,9
    enq(3'd0, 6'd5, 12'h1);
    enq(3'd0, 6'd2, 12'h2);
    enq(3'd0, 6'd9, 12'h3);
    chk("t1_count3", 32'(out_count), 3);
    deq(el(3'd0, 6'd2, 12'h2));
    deq(el(3'd0, 6'd5, 12'h1));
    deq(el(3'd0, 6'd9, 12'h3));
    chk("t1_count0", 32'(out_count), 0);
    chk("t1_empty", 32'(out_empty), 1);
    // 2: full array, enq+deq still accepted
    do_reset();
    for (int i = 0; i < 16; i++) enq(3'd2, 6'(i), 12'(i));
    chk("t2_full", 32'(out_full), 1);
    chk("t2_count16", 32'(out_count), 16);
    set_enq(1'b1, 3'd2, 6'd7, 12'h77);
    #1;
    chk("t2_enq_ready_full", 32'(s_enq_ready), 0);
    s_deq_valid = 1'b1;
    #1;
    chk("t2_enq_ready_deq", 32'(s_enq_ready), 1);
    chk("t2_strobes", {30'd0, out_ctl_insert, out_ctl_pop}, 3);
    expect_deq(el(3'd2, 6'd0, 12'h0));
    step();
    s_enq_valid = 1'b0;
    s_deq_valid = 1'b0;
    chk("t2_count_stays", 32'(out_count), 16);
    // 3: bypass, new rank beats head
    do_reset();
    enq(3'd0, 6'd4, 12'h040);
    set_enq(1'b1, 3'd5, 6'd1, 12'hABC);
    s_deq_valid = 1'b1;
    #1;
    chk("t3_enq_ready", 32'(s_enq_ready), 1);
    chk("t3_strobes", {30'd0, out_ctl_insert, out_ctl_pop}, 0);
    chk("t3_input_valid", 32'(element_valid(out_pifo_input)), 0);
    expect_deq(el(3'd5, 6'd1, 12'hABC));
    step();
    s_enq_valid = 1'b0;
    s_deq_valid = 1'b0;
    chk("t3_count", 32'(out_count), 1);
    chk("t3_head", 32'(in_pifo_head), 32'(el(3'd0, 6'd4, 12'h040)));
    // 4: tie goes to the array
    set_enq(1'b1, 3'd0, 6'd4, 12'h010);
    s_deq_valid = 1'b1;
    #1;
    chk("t4_strobes", {30'd0, out_ctl_insert, out_ctl_pop}, 3);
    expect_deq(el(3'd0, 6'd4, 12'h040));
    step();
    s_enq_valid = 1'b0;
    s_deq_valid = 1'b0;
    chk("t4_count", 32'(out_count), 1);
    chk("t4_head", 32'(in_pifo_head), 32'(el(3'd0, 6'd4, 12'h010)));
    deq(el(3'd0, 6'd4, 12'h010));
    // 5: dequeue on empty
    s_deq_valid = 1'b1;
    #1;
    chk("t5_deq_ready", 32'(s_deq_ready), 0);
    chk("t5_pop", 32'(out_ctl_pop), 0);
    step();
    step();
    s_deq_valid = 1'b0;
    chk("t5_count", 32'(out_count), 0);
    // 6: flush 5 entries
    for (int i = 0; i < 5; i++) enq(3'd1, 6'(10 + i), 12'(i));
    chk("t6_count5", 32'(out_count), 5);
    in_flush = 1'b1;
    set_enq(1'b1, 3'd1, 6'd0, 12'h0);
    s_deq_valid = 1'b1;
    #1;
    chk("t6_ready_flush", {30'd0, s_enq_ready, s_deq_ready}, 0);
    step();
    in_flush = 1'b0;
    s_enq_valid = 1'b0;
    s_deq_valid = 1'b0;
    busy_n = 0;
    pop_n = 0;
    for (int k = 0; k < 20 && out_busy; k++) begin
      busy_n++;
      pop_n += int'(out_ctl_pop);
      step();
    end
    chk("t6_busy_cycles", 32'(busy_n), 6);
    chk("t6_pop_cycles", 32'(pop_n), 5);
    chk("t6_count0", 32'(out_count), 0);
    chk("t6_run", 32'(out_busy), 0);
    in_flush = 1'b1;
    step();
    in_flush = 1'b0;
    chk("t6_empty_flush_done", 32'(out_busy), 1);
    step();
    chk("t6_empty_flush_run", 32'(out_busy), 0);
    for (int i = 0; i < 3; i++) enq(3'd1, 6'(i), 12'(i));
    in_flush = 1'b1;
    step();
    in_flush = 1'b0;
    step();
    chk("t6_midflush_busy", 32'(out_busy), 1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("t6_rst_busy", 32'(out_busy), 0);
    chk("t6_rst_count", 32'(out_count), 0);
    step();
    step();
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
